// File: rtl/regfile_stage.sv
// regfile_stage: register-file read stage of an in-order pipeline.
//
// Holds NREGS architectural registers of XLEN bits, with register 0 hard-wired
// to zero. There are NRD combinational read ports, and their results are
// captured into registered outputs for the next stage. One write port comes
// from writeback.
//
// Optional feature, selected by the macro REGFILE_STAGE_BYPASS_EN:
//   defined   - a qualifying write is forwarded (write-through) to any lane
//               reading the same address in the same cycle. It is also
//               forwarded into held lanes while the stage is stalled.
//   undefined - reads see the pre-write contents, and stalled output lanes
//               hold unchanged.
//
// Handshake: valid_out qualifies rd_data/rd_addr_q for the downstream stage.
// There is no ready signal. Backpressure arrives as stall, which freezes
// valid_out and rd_addr_q. A flush wins over stall and empties the stage
// (valid_out=0, data and address cleared). Writes are independent of
// valid/stall/flush.

module regfile_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    input  logic                stall,
    input  logic                flush,
    input  logic [NRD*$clog2(NREGS)-1:0] rd_addr,
    input  logic                we,
    input  logic [$clog2(NREGS)-1:0]     wa,
    input  logic [XLEN-1:0]     wd,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD*$clog2(NREGS)-1:0] rd_addr_q,
    output logic                valid_out
);

    localparam int AW = $clog2(NREGS);

    // One extra bit so the range check never degenerates into a constant
    // comparison when NREGS is a power of two.
    localparam logic [AW:0] NREGS_LIM = (AW+1)'(NREGS);

    // Architectural state. Entry 0 is cleared by reset and never written.
    logic [XLEN-1:0] regs [NREGS];

    // Per-lane views of the packed ports.
    logic [AW-1:0]   lane_addr   [NRD];
    logic [AW-1:0]   lane_addr_q [NRD];
    logic [XLEN-1:0] lane_rdval  [NRD];

    // Next values of the stage output registers.
    logic [XLEN-1:0] rd_data_n   [NRD];
    logic [AW-1:0]   rd_addr_q_n [NRD];
    logic            valid_out_n;

    // Registered outputs kept in lane form.
    logic [XLEN-1:0] rd_data_r   [NRD];
    logic [AW-1:0]   rd_addr_q_r [NRD];
    logic            valid_out_r;

    // A write lands only for a nonzero, in-range address.
    logic wr_hit;

    // Qualify the writeback request.
    always_comb begin
        wr_hit = we && (wa != '0) && ({1'b0, wa} < NREGS_LIM);
    end

    // Split the packed address ports into lanes.
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            lane_addr[k]   = rd_addr[k*AW +: AW];
            lane_addr_q[k] = rd_addr_q[k*AW +: AW];
        end
    end

    // Combinational read of each lane. Register 0 and out-of-range addresses
    // read as zero.
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            lane_rdval[k] = '0;
            if ((lane_addr[k] != '0) && ({1'b0, lane_addr[k]} < NREGS_LIM)) begin
`ifdef REGFILE_STAGE_BYPASS_EN
                if (wr_hit && (wa == lane_addr[k])) begin
                    lane_rdval[k] = wd;
                end else begin
                    lane_rdval[k] = regs[lane_addr[k]];
                end
`else
                lane_rdval[k] = regs[lane_addr[k]];
`endif
            end
        end
    end

    // Decide what the stage registers take on the next edge: flush, capture,
    // or hold.
    always_comb begin
        valid_out_n = valid_out_r;
        for (int k = 0; k < NRD; k++) begin
            rd_data_n[k]   = rd_data_r[k];
            rd_addr_q_n[k] = rd_addr_q_r[k];
        end
        if (flush) begin
            valid_out_n = 1'b0;
            for (int k = 0; k < NRD; k++) begin
                rd_data_n[k]   = '0;
                rd_addr_q_n[k] = '0;
            end
        end else if (!stall) begin
            valid_out_n = valid_in;
            for (int k = 0; k < NRD; k++) begin
                rd_data_n[k]   = lane_rdval[k];
                rd_addr_q_n[k] = lane_addr[k];
            end
        end else begin
`ifdef REGFILE_STAGE_BYPASS_EN
            // Keep held operands coherent with writes that land during a
            // stall. wr_hit excludes address 0 and out-of-range addresses,
            // so those lanes never match.
            for (int k = 0; k < NRD; k++) begin
                if (wr_hit && (lane_addr_q[k] == wa)) begin
                    rd_data_n[k] = wd;
                end
            end
`endif
        end
    end

    // Register file state: async clear, single write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[wa] <= wd;
        end
    end

    // Stage output registers: async clear, next values from the decision logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_out_r <= 1'b0;
            for (int k = 0; k < NRD; k++) begin
                rd_data_r[k]   <= '0;
                rd_addr_q_r[k] <= '0;
            end
        end else begin
            valid_out_r <= valid_out_n;
            for (int k = 0; k < NRD; k++) begin
                rd_data_r[k]   <= rd_data_n[k];
                rd_addr_q_r[k] <= rd_addr_q_n[k];
            end
        end
    end

    // Pack the lane registers onto the output ports.
    always_comb begin
        valid_out = valid_out_r;
        for (int k = 0; k < NRD; k++) begin
            rd_data[k*XLEN +: XLEN] = rd_data_r[k];
            rd_addr_q[k*AW +: AW]   = rd_addr_q_r[k];
        end
    end

endmodule

// File: doc/regfile_stage.md
REGFILE_STAGE -- requirements
Module: regfile_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, the data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, the number of architectural registers (2..64).
REQ-003 SHALL have parameter NRD, default 2, the number of read ports (1..4).
REQ-004 SHALL derive AW = clog2(NREGS) as a local parameter.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 valid_in  input  1  decode-stage instruction valid.
REQ-008 stall  input  1  hold the stage output registers.
REQ-009 flush  input  1  invalidate the stage output.
REQ-010 rd_addr  input  NRD*AW  read addresses; lane k is bits [k*AW +: AW].
REQ-011 we  input  1  write enable from writeback.
REQ-012 wa  input  AW  write address.
REQ-013 wd  input  XLEN  write data.
REQ-014 rd_data  output  NRD*XLEN  registered read data; lane k is bits [k*XLEN +: XLEN].
REQ-015 rd_addr_q  output  NRD*AW  registered copy of the captured read addresses.
REQ-016 valid_out  output  1  registered valid for the downstream stage.

Function
REQ-017 SHALL hold NREGS registers of XLEN bits; register 0 SHALL always read 0.
REQ-018 Register write SHALL occur on the rising clk edge when we=1, wa!=0 and wa<NREGS; otherwise no register changes.
REQ-019 When stall=0 and flush=0, each rising edge SHALL set rd_data lane k = value(rd_addr lane k), rd_addr_q = rd_addr and valid_out = valid_in; latency is 1 cycle.
REQ-020 value(a) SHALL be 0 for a=0 or a>=NREGS, otherwise the register contents as defined in REQ-030/REQ-031.
REQ-021 When flush=1, the rising edge SHALL set valid_out=0, rd_data=0 and rd_addr_q=0, regardless of stall.
REQ-022 When stall=1 and flush=0, valid_out and rd_addr_q SHALL hold, and rd_data SHALL follow REQ-032/REQ-033.
REQ-023 Writes (REQ-018) SHALL proceed independently of stall, flush and valid_in.
REQ-024 Multiple lanes with the same address SHALL return identical data.

Reset
REQ-025 Asserting reset SHALL immediately clear all registers to 0.
REQ-026 Asserting reset SHALL immediately clear rd_data, rd_addr_q and valid_out to 0.
REQ-027 While reset=1, writes SHALL be ignored.
REQ-028 Reset asserted mid-stall SHALL discard the held state.
REQ-029 On the first rising edge after reset deasserts, the block SHALL operate normally.

Configuration
REQ-030 With macro REGFILE_STAGE_BYPASS_EN defined, a read of address a in the same cycle as a qualifying write to a SHALL return wd (write-through).
REQ-031 Without REGFILE_STAGE_BYPASS_EN, such a read SHALL return the pre-write contents; the new value is visible from the next cycle.
REQ-032 With REGFILE_STAGE_BYPASS_EN defined and stall=1, any lane whose rd_addr_q equals a qualifying wa SHALL update to wd; all other lanes hold.
REQ-033 Without REGFILE_STAGE_BYPASS_EN and stall=1, rd_data SHALL hold unchanged.

Verification
REQ-034 Reset, then we=1, wa=5, wd=0xDEADBEEF; next cycle rd_addr lane0=5 -> rd_data lane0=0xDEADBEEF one cycle later, valid_out follows valid_in.
REQ-035 we=1, wa=0, wd=0x1234; read address 0 -> rd_data=0 on every lane.
REQ-036 Same-cycle write wa=7, wd=0xA5A5A5A5 with read address 7 (reg7 previously 0x11) -> 0xA5A5A5A5 with BYPASS_EN; 0x11 without it.
REQ-037 Capture address 3 (value 0x22), then stall=1 while writing wa=3, wd=0x33 -> rd_data 0x33 with BYPASS_EN; 0x22 without; valid_out held.
REQ-038 stall=1 and flush=1 together with valid_out=1 -> valid_out=0 and rd_data=0 next edge; writes in that cycle still land.
REQ-039 Assert reset asynchronously mid-cycle with valid_out=1 and reg9=0xFF -> valid_out=0 immediately; read of address 9 after release returns 0.
